// File: rtl/syn_cpu_pkg.sv
// Shared opcodes, ALU/writeback selectors and constants for the syn_cpu single-cycle RV32I core.
package syn_cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0]  DM_CTL_IDLE  = 4'b0011;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd,
    AluPassB
  } alu_op_e;

  typedef enum logic [1:0] {
    WbAlu,
    WbPc4,
    WbLoad
  } wb_sel_e;

endpackage

// File: rtl/syn_cpu_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module syn_cpu_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];

endmodule

// File: rtl/syn_cpu.sv
// Single-cycle RV32I core with external instruction/data memories.
// Define SYNCPU_HALT_EN to make EBREAK/unknown opcodes halt the core and add a halted output.
module syn_cpu
  import syn_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_inst,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_store,
  output logic [3:0]  dm_ctl,
  input  logic [31:0] dm_load
`ifdef SYNCPU_HALT_EN
  ,
  output logic        halted
`endif
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_a, alu_b, alu_res;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        rd_we, rf_we;
  logic [31:0] wb_data;
  logic [31:0] mem_imm, mem_addr;
  logic [3:0]  ctl_raw;
  logic        br_eq, br_lt, br_ltu, br_taken;
  logic        illegal, is_ebreak, halt_req;
  logic        halt_active, freeze;

  assign opcode    = im_inst[6:0];
  assign rd        = im_inst[11:7];
  assign funct3    = im_inst[14:12];
  assign rs1       = im_inst[19:15];
  assign rs2       = im_inst[24:20];
  assign funct7_b5 = im_inst[30];

  assign imm_i = {{20{im_inst[31]}}, im_inst[31:20]};
  assign imm_s = {{20{im_inst[31]}}, im_inst[31:25], im_inst[11:7]};
  assign imm_b = {{19{im_inst[31]}}, im_inst[31], im_inst[7], im_inst[30:25], im_inst[11:8], 1'b0};
  assign imm_u = {im_inst[31:12], 12'd0};
  assign imm_j = {{11{im_inst[31]}}, im_inst[31], im_inst[19:12], im_inst[20],
                  im_inst[30:21], 1'b0};

  assign pc_plus4 = pc_q + 32'd4;

  syn_cpu_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst),
    .raddr_a_i (rs1),
    .rdata_a_o (rs1_data),
    .raddr_b_i (rs2),
    .rdata_b_o (rs2_data),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (wb_data)
  );

  assign br_eq  = (rs1_data == rs2_data);
  assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign br_ltu = (rs1_data < rs2_data);

  always_comb begin
    unique case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Decode: ALU operands/op, writeback source, memory control and next PC.
  always_comb begin
    alu_op    = AluAdd;
    alu_a     = rs1_data;
    alu_b     = imm_i;
    wb_sel    = WbAlu;
    rd_we     = 1'b0;
    ctl_raw   = DM_CTL_IDLE;
    mem_imm   = imm_i;
    pc_d      = pc_plus4;
    illegal   = 1'b0;
    is_ebreak = 1'b0;

    unique case (opcode)
      OP_LUI: begin
        alu_op = AluPassB;
        alu_b  = imm_u;
        rd_we  = 1'b1;
      end
      OP_AUIPC: begin
        alu_a = pc_q;
        alu_b = imm_u;
        rd_we = 1'b1;
      end
      OP_JAL: begin
        wb_sel = WbPc4;
        rd_we  = 1'b1;
        pc_d   = pc_q + imm_j;
      end
      OP_JALR: begin
        wb_sel = WbPc4;
        rd_we  = 1'b1;
        pc_d   = {alu_res[31:1], 1'b0};
      end
      OP_BRANCH: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OP_LOAD: begin
        wb_sel  = WbLoad;
        rd_we   = 1'b1;
        ctl_raw = {1'b0, funct3};
      end
      OP_STORE: begin
        mem_imm = imm_s;
        ctl_raw = {1'b1, funct3};
      end
      OP_IMM, OP_REG: begin
        rd_we = 1'b1;
        if (opcode == OP_REG) alu_b = rs2_data;
        unique case (funct3)
          3'b000:  alu_op = (opcode == OP_REG && funct7_b5) ? AluSub : AluAdd;
          3'b001:  alu_op = AluSll;
          3'b010:  alu_op = AluSlt;
          3'b011:  alu_op = AluSltu;
          3'b100:  alu_op = AluXor;
          3'b101:  alu_op = funct7_b5 ? AluSra : AluSrl;
          3'b110:  alu_op = AluOr;
          default: alu_op = AluAnd;
        endcase
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        is_ebreak = (im_inst == INST_EBREAK);
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    unique case (alu_op)
      AluAdd:   alu_res = alu_a + alu_b;
      AluSub:   alu_res = alu_a - alu_b;
      AluSll:   alu_res = alu_a << alu_b[4:0];
      AluSlt:   alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      AluSltu:  alu_res = {31'd0, alu_a < alu_b};
      AluXor:   alu_res = alu_a ^ alu_b;
      AluSrl:   alu_res = alu_a >> alu_b[4:0];
      AluSra:   alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      AluOr:    alu_res = alu_a | alu_b;
      AluAnd:   alu_res = alu_a & alu_b;
      default:  alu_res = alu_b;
    endcase
  end

  always_comb begin
    unique case (wb_sel)
      WbPc4:   wb_data = pc_plus4;
      WbLoad:  wb_data = dm_load;
      default: wb_data = alu_res;
    endcase
  end

  assign halt_req = illegal | is_ebreak;

`ifdef SYNCPU_HALT_EN
  logic halted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (halt_req) begin
      halted_q <= 1'b1;
    end
  end

  assign halt_active = halted_q;
  // The halting instruction itself leaves the PC pointing at it.
  assign freeze      = halted_q | halt_req;
  assign halted      = halted_q;
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt_active     = 1'b0;
  assign freeze          = 1'b0;
`endif

  assign rf_we = rd_we & ~halt_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (!freeze) begin
      pc_q <= pc_d;
    end
  end

  assign mem_addr = rs1_data + mem_imm;

  // Memory outputs are forced quiet while reset is held so an in-flight store is dropped.
  assign im_addr  = pc_q;
  assign dm_ctl   = (rst && !halt_active) ? ctl_raw : DM_CTL_IDLE;
  assign dm_addr  = rst ? mem_addr : 32'd0;
  assign dm_store = rst ? rs2_data : 32'd0;

endmodule

// File: tb/tb_syn_cpu.sv
// Directed, table-driven bench for syn_cpu: one row per executed instruction plus reset sequences.
module tb_syn_cpu;

  localparam logic [3:0] IDLE = 4'b0011;
  localparam logic [6:0] OPI  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr, im_inst, dm_addr, dm_store, dm_load;
  logic [3:0]  dm_ctl;
`ifdef SYNCPU_HALT_EN
  logic        halted;
`endif

  syn_cpu #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .im_addr  (im_addr),
    .im_inst  (im_inst),
    .dm_addr  (dm_addr),
    .dm_store (dm_store),
    .dm_ctl   (dm_ctl),
    .dm_load  (dm_load)
`ifdef SYNCPU_HALT_EN
    ,
    .halted   (halted)
`endif
  );

  always #5 clk = ~clk;

  // Word-only data memory model; the bench only issues LW.
  logic [31:0] dmem [64];
  int          n_writes = 0;

  assign dm_load = dmem[dm_addr[7:2]];

  always @(posedge clk) begin
    if (dm_ctl[3]) begin
      n_writes <= n_writes + 1;
      if (dm_ctl[2:0] == 3'b010) dmem[dm_addr[7:2]] <= dm_store;
    end
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] exp_pc;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
    bit          chk_mem;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] ctl,
                         input logic [31:0] addr, input logic [31:0] store, input bit chk);
    vec_t v;
    v.inst = inst; v.exp_pc = pc; v.exp_ctl = ctl;
    v.exp_addr = addr; v.exp_store = store; v.chk_mem = chk;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic unused_lsb;
    unused_lsb = imm[0];
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    logic unused_lsb;
    unused_lsb = imm[0];
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  initial begin
    // inst, pc, dm_ctl, dm_addr, dm_store, check address/data
    add_vec(enc_i(12'd114, 5'd0, 3'd0, 5'd1, OPI),        32'h00, IDLE,    0, 0, 0);
    add_vec(enc_i(12'd514, 5'd0, 3'd0, 5'd2, OPI),        32'h04, IDLE,    0, 0, 0);
    add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),         32'h08, IDLE,    0, 0, 0);
    add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),         32'h0C, IDLE,    0, 0, 0);
    add_vec(enc_b(13'd12, 5'd1, 5'd1, 3'd0),              32'h10, IDLE,    0, 0, 0);
    add_vec(enc_b(13'd8, 5'd1, 5'd1, 3'd1),               32'h1C, IDLE,    0, 0, 0);
    add_vec(enc_j(21'd16, 5'd9),                          32'h20, IDLE,    0, 0, 0);
    add_vec(enc_s(12'd8, 5'd3, 5'd0, 3'd2),               32'h30, 4'b1010, 8, 32'd628, 1);
    add_vec(enc_i(12'd8, 5'd0, 3'd2, 5'd5, 7'b0000011),   32'h34, 4'b0010, 8, 32'd0, 1);
    add_vec(enc_s(12'd12, 5'd5, 5'd0, 3'd2),              32'h38, 4'b1010, 12, 32'd628, 1);
    add_vec(enc_s(12'd16, 5'd4, 5'd0, 3'd2),              32'h3C, 4'b1010, 16, 32'hFFFF_FE70, 1);
    add_vec(enc_s(12'd20, 5'd9, 5'd0, 3'd2),              32'h40, 4'b1010, 20, 32'h24, 1);
    add_vec(enc_i(12'hFFF, 5'd0, 3'd0, 5'd6, OPI),        32'h44, IDLE,    0, 0, 0);
    add_vec(enc_i(12'h404, 5'd6, 3'd5, 5'd7, OPI),        32'h48, IDLE,    0, 0, 0);
    add_vec(enc_i(12'd28, 5'd6, 3'd5, 5'd8, OPI),         32'h4C, IDLE,    0, 0, 0);
    add_vec(enc_r(7'h00, 5'd1, 5'd6, 3'd2, 5'd10),        32'h50, IDLE,    0, 0, 0);
    add_vec(enc_r(7'h00, 5'd1, 5'd6, 3'd3, 5'd11),        32'h54, IDLE,    0, 0, 0);
    add_vec(enc_s(12'd24, 5'd7, 5'd0, 3'd2),              32'h58, 4'b1010, 24, 32'hFFFF_FFFF, 1);
    add_vec(enc_s(12'd28, 5'd8, 5'd0, 3'd2),              32'h5C, 4'b1010, 28, 32'h0000_000F, 1);
    add_vec(enc_s(12'd32, 5'd10, 5'd0, 3'd2),             32'h60, 4'b1010, 32, 32'd1, 1);
    add_vec(enc_s(12'd36, 5'd11, 5'd0, 3'd2),             32'h64, 4'b1010, 36, 32'd0, 1);
    add_vec(enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI),          32'h68, IDLE,    0, 0, 0);
    add_vec(enc_s(12'd40, 5'd0, 5'd0, 3'd2),              32'h6C, 4'b1010, 40, 32'd0, 1);
    add_vec(enc_i(12'd1, 5'd9, 3'd0, 5'd13, 7'b1100111),  32'h70, IDLE,    0, 0, 0);
    add_vec(enc_s(12'd44, 5'd13, 5'd0, 3'd2),             32'h24, 4'b1010, 44, 32'h74, 1);
    add_vec(32'h0000_0073,                                32'h28, IDLE,    0, 0, 0);
    add_vec(enc_b(13'd8, 5'd1, 5'd6, 3'd4),               32'h2C, IDLE,    0, 0, 0);
    add_vec(enc_b(13'h1FCC, 5'd1, 5'd6, 3'd7),            32'h34, IDLE,    0, 0, 0);
    add_vec(enc_i(12'd7, 5'd0, 3'd0, 5'd1, OPI),          32'h00, IDLE,    0, 0, 0);
    add_vec(enc_u(20'h12345, 5'd14, 7'b0110111),          32'h04, IDLE,    0, 0, 0);
    add_vec(enc_u(20'h00001, 5'd15, 7'b0010111),          32'h08, IDLE,    0, 0, 0);
    add_vec(enc_s(12'd48, 5'd14, 5'd0, 3'd2),             32'h0C, 4'b1010, 48, 32'h1234_5000, 1);
    add_vec(enc_s(12'd52, 5'd15, 5'd0, 3'd2),             32'h10, 4'b1010, 52, 32'h0000_1008, 1);
    add_vec(enc_s(12'd3, 5'd1, 5'd0, 3'd0),               32'h14, 4'b1000, 3, 32'd7, 1);

    // Reset held for three cycles with a store on the instruction bus: outputs must stay quiet.
    rst     = 1'b0;
    im_inst = enc_s(12'd8, 5'd3, 5'd0, 3'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_pc[%0d]", c), im_addr, 32'h0);
      check($sformatf("rst_ctl[%0d]", c), {28'd0, dm_ctl}, {28'd0, IDLE});
      check($sformatf("rst_addr[%0d]", c), dm_addr, 32'h0);
      check($sformatf("rst_store[%0d]", c), dm_store, 32'h0);
    end
    check("rst_no_write", n_writes, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      im_inst = vecs[i].inst;
      #1;
      check($sformatf("pc[%0d]", i), im_addr, vecs[i].exp_pc);
      check($sformatf("ctl[%0d]", i), {28'd0, dm_ctl}, {28'd0, vecs[i].exp_ctl});
      if (vecs[i].chk_mem) begin
        check($sformatf("addr[%0d]", i), dm_addr, vecs[i].exp_addr);
        check($sformatf("store[%0d]", i), dm_store, vecs[i].exp_store);
      end
`ifdef SYNCPU_HALT_EN
      check($sformatf("halted[%0d]", i), {31'd0, halted}, 32'd0);
`endif
      @(posedge clk);
      @(negedge clk);
    end

    // Mid-program reset while a store is on the bus: PC clears at once and the store is dropped.
    im_inst = enc_s(12'd48, 5'd3, 5'd0, 3'd2);
    #1;
    check("mid_pc_before", im_addr, 32'h18);
    check("mid_ctl_before", {28'd0, dm_ctl}, 32'h0000_000A);
    #2;
    rst = 1'b0;
    #1;
    check("mid_pc_async", im_addr, 32'h0);
    check("mid_ctl_async", {28'd0, dm_ctl}, {28'd0, IDLE});
    check("mid_addr_async", dm_addr, 32'h0);
    check("mid_store_async", dm_store, 32'h0);
    begin
      int w0;
      w0 = n_writes;
      @(posedge clk);
      @(negedge clk);
      check("mid_no_write", n_writes, w0);
    end
    rst     = 1'b1;
    im_inst = enc_s(12'd8, 5'd3, 5'd0, 3'd2);
    #1;
    check("post_pc", im_addr, 32'h0);
    check("post_ctl", {28'd0, dm_ctl}, 32'h0000_000A);
    check("post_x3_cleared", dm_store, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("post_pc_next", im_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/syn_cpu.md
Name: syn_cpu

Overview:
- Single-cycle RV32I processor core: fetch, decode, execute, memory and writeback all complete in one clk period.
- Connects to an external instruction memory (im_addr/im_inst) and an external data memory (dm_addr/dm_store/dm_load/dm_ctl).
- Top-level compute block of the SoC; memories sit outside it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- im_addr  output  32  current PC, byte address to instruction memory.
- im_inst  input  32  instruction at im_addr; combinational, valid in the same cycle.
- dm_addr  output  32  data byte address, rs1 + immediate.
- dm_store  output  32  store data, rs2 unshifted; the data memory places byte lanes.
- dm_ctl  output  4  bit3 = write, bits[2:0] = funct3 of the load/store; 4'b0011 = idle (no access).
- dm_load  input  32  load result, already lane-aligned and sign/zero-extended by the data memory per dm_ctl; combinational.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst.
- Reset asserted (rst=0):
  - PC <= RESET_PC immediately; x1..x31 <= 0.
  - Outputs: im_addr=RESET_PC, dm_ctl=4'b0011, dm_addr=0, dm_store=0.
- Reset deasserted: first instruction executes on the first rising edge.
- Reset asserted mid-instruction aborts it: no register write, no memory write.
- Per cycle:
  - im_inst is decoded combinationally.
  - At posedge: rd is written (if any) and the PC updates.
  - Load data is captured through dm_load in the same cycle.
  - The store takes effect at the data memory on the same posedge.
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP of RV32I.
- FENCE, ECALL, EBREAK, SYSTEM and unknown opcodes execute as NOP: PC+4, no writes.
- x0 always reads 0; writes to x0 are discarded.
- Register file: two combinational read ports, one write port. A same-cycle read of the register being written returns the old value.
- Next PC:
  - default PC+4
  - taken branch: PC+B-imm
  - JAL: PC+J-imm
  - JALR: (rs1+I-imm) & ~1
  - JAL/JALR write PC+4 to rd.
- Arithmetic:
  - 32-bit wrap-around on add/sub; no overflow flags.
  - Shift amount is the low 5 bits (rs2[4:0] or shamt).
  - SRA/SRAI are arithmetic.
  - SLT/SLTI/BLT/BGE are signed; SLTU/SLTIU/BLTU/BGEU are unsigned.
  - SLTIU sign-extends the immediate before the unsigned compare.
- Misaligned PC or data addresses raise no exception. The address is passed through unchanged; data memory behaviour on misalignment is its own concern.
- dm_ctl drive rules:
  - Loads: {1'b0, funct3}.
  - Stores: {1'b1, funct3}.
  - All other instructions: 4'b0011.

Optional Feature:
- Macro SYNCPU_HALT_EN.
- Defined:
  - EBREAK or any unknown opcode sets a sticky halted flag at posedge.
  - While halted: PC frozen, no register writes, dm_ctl=4'b0011.
  - Flag cleared only by reset.
  - Adds output port halted (1 bit), 0 at reset.
- Undefined: no halted port; these instructions are NOPs.

Decomposition:
- Package syn_cpu_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM)
  - ALU-op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B)
  - DM_CTL_IDLE = 4'b0011
  - RESET_PC default
- One natural sub-module: syn_cpu_regfile (32x32, x0 hardwired, async reset, 2R/1W).
- ALU, immediate generation and next-PC logic stay in syn_cpu.

Test Plan:
- Hold rst=0 for 3 cycles, then release -> im_addr=0, dm_ctl=4'b0011 during reset; im_addr=4 after the first posedge.
- addi x1,x0,114; addi x2,x0,514; add x3,x1,x2 -> x3=628; then sub x4,x1,x2 -> x4=32'hFFFF_FE70.
- sw x3,8(x0) then lw x5,8(x0) -> sw cycle: dm_ctl=4'b1010, dm_addr=8, dm_store=628; lw cycle: dm_ctl=4'b0010; x5=628.
- addi x6,x0,-1; srai x7,x6,4 / srli x8,x6,28; slt/sltu x1,x6 -> x7=FFFF_FFFF, x8=0000_000F, slt=1, sltu=0.
- beq x1,x1,+12 taken, bne x1,x1,+8 not taken, jal x9,+16 at PC=0x20, jalr x0,0(x9) -> PCs correct; x9=0x24; JALR target bit0 cleared.
- addi x0,x0,5 then read x0 -> 0. Assert rst mid-program -> PC=0 and regs=0 immediately, before the next clock edge.
